disparity_search_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the 16-unit parallel disparity matcher.
- NUM_UNITS parallel SAD accumulators are reused over NUM_PASSES passes, so the search covers NUM_UNITS*NUM_PASSES candidate disparities with a streaming valid/ready pixel interface.
- Each pass ends with an argmin reduction that is merged into a running best.
- Outputs one disparity, its cost and a confidence flag per search, through a valid/ready result port.
- Sits between the window/address generator and the depth-map writer.

---
 rtl/disparity_search_seq.sv | 210 +++++++++++++++++++++
 tb/tb_disparity_search_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_search_seq.sv
// Time-multiplexed stereo disparity search: NUM_UNITS SAD accumulators are reused over
// NUM_PASSES passes, with a per-pass argmin merged into a running best result.
module disparity_search_seq #(
   parameter int PIX_W      = 3,
   parameter int NUM_UNITS  = 16,
   parameter int NUM_PASSES = 2,
   parameter int WIN_LEN    = 16,
   localparam int COST_W    = $clog2(WIN_LEN * ((1 << PIX_W) - 1) + 1),
   localparam int DISP_W    = $clog2(NUM_UNITS * NUM_PASSES),
   localparam int PASS_W    = $clog2(NUM_PASSES) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [COST_W-1:0]          cfg_thresh,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PIX_W-1:0]           in_g,
   input  logic [NUM_UNITS*PIX_W-1:0] in_f,
   output logic                       busy,
   output logic [PASS_W-1:0]          pass_idx,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DISP_W-1:0]          out_disp,
   output logic [COST_W-1:0]          out_cost,
   output logic                       out_conf
);

   localparam int BEAT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int LVL    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 0;
   localparam int LEAVES = 1 << LVL;
   localparam int NODES  = 2 * LEAVES - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_REDUCE,
      S_OUTPUT
   } state_t;

   state_t state_q, state_d;

   logic [COST_W-1:0] acc_q [NUM_UNITS];
   logic [BEAT_W-1:0] beat_q;
   logic [PASS_W-1:0] pass_q;
   logic [COST_W-1:0] best_cost_q;
   logic [DISP_W-1:0] best_disp_q;
   logic [COST_W-1:0] thresh_q;

   logic [PIX_W-1:0]  diff [NUM_UNITS];
   logic [COST_W-1:0] node_cost [NODES];
   logic [UNIT_W-1:0] node_idx [NODES];
   logic [COST_W-1:0] tree_min;
   logic [UNIT_W-1:0] tree_idx;
   logic [DISP_W-1:0] cand_disp;
   logic [COST_W-1:0] merge_cost;
   logic [DISP_W-1:0] merge_disp;
   logic              beat_fire;
   logic              last_beat;
   logic              last_pass;

   assign last_beat = (beat_q == BEAT_W'(WIN_LEN - 1));
   assign last_pass = (pass_q == PASS_W'(NUM_PASSES - 1));

   always_comb begin
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
         if (in_f[u*PIX_W +: PIX_W] >= in_g)
            diff[u] = in_f[u*PIX_W +: PIX_W] - in_g;
         else
            diff[u] = in_g - in_f[u*PIX_W +: PIX_W];
      end
   end

   // Padded binary tree; unused leaves hold all-ones and lose ties, left child wins ties.
   always_comb begin
      for (int unsigned i = 0; i < NODES; i++) begin
         node_cost[i] = '1;
         node_idx[i]  = '0;
      end
      for (int unsigned i = 0; i < LEAVES; i++) begin
         if (i < NUM_UNITS) begin
            node_cost[LEAVES-1+i] = acc_q[i];
            node_idx[LEAVES-1+i]  = UNIT_W'(i);
         end
      end
      for (int unsigned k = 0; k + 1 < LEAVES; k++) begin
         if (node_cost[2*(LEAVES-2-k)+2] < node_cost[2*(LEAVES-2-k)+1]) begin
            node_cost[LEAVES-2-k] = node_cost[2*(LEAVES-2-k)+2];
            node_idx[LEAVES-2-k]  = node_idx[2*(LEAVES-2-k)+2];
         end else begin
            node_cost[LEAVES-2-k] = node_cost[2*(LEAVES-2-k)+1];
            node_idx[LEAVES-2-k]  = node_idx[2*(LEAVES-2-k)+1];
         end
      end
   end

   assign tree_min  = node_cost[0];
   assign tree_idx  = node_idx[0];
   assign cand_disp = DISP_W'(int'(pass_q) * NUM_UNITS + int'(tree_idx));

   // Strict compare keeps the earlier pass (smaller disparity) on cross-pass ties.
   always_comb begin
      merge_cost = best_cost_q;
      merge_disp = best_disp_q;
      if (tree_min < best_cost_q) begin
         merge_cost = tree_min;
         merge_disp = cand_disp;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      pass_idx  = '0;
      beat_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               state_d = S_ACCUM;
         end
         S_ACCUM: begin
            in_ready  = 1'b1;
            pass_idx  = pass_q;
            beat_fire = in_valid;
            if (in_valid && last_beat)
               state_d = S_REDUCE;
         end
         S_REDUCE: begin
            pass_idx = pass_q;
            state_d  = last_pass ? S_OUTPUT : S_ACCUM;
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort)
         state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned u = 0; u < NUM_UNITS; u++)
            acc_q[u] <= '0;
         beat_q      <= '0;
         pass_q      <= '0;
         best_cost_q <= '0;
         best_disp_q <= '0;
         thresh_q    <= '0;
         out_disp    <= '0;
         out_cost    <= '0;
         out_conf    <= 1'b0;
      end else if (abort) begin
         for (int unsigned u = 0; u < NUM_UNITS; u++)
            acc_q[u] <= '0;
         beat_q <= '0;
         pass_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int unsigned u = 0; u < NUM_UNITS; u++)
                     acc_q[u] <= '0;
                  thresh_q    <= cfg_thresh;
                  beat_q      <= '0;
                  pass_q      <= '0;
                  best_cost_q <= '1;
                  best_disp_q <= '0;
               end
            end
            S_ACCUM: begin
               if (beat_fire) begin
                  for (int unsigned u = 0; u < NUM_UNITS; u++)
                     acc_q[u] <= acc_q[u] + COST_W'(diff[u]);
                  beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
               end
            end
            S_REDUCE: begin
               for (int unsigned u = 0; u < NUM_UNITS; u++)
                  acc_q[u] <= '0;
               best_cost_q <= merge_cost;
               best_disp_q <= merge_disp;
               if (last_pass) begin
                  out_disp <= merge_disp;
                  out_cost <= merge_cost;
                  out_conf <= (merge_cost <= thresh_q);
               end else begin
                  pass_q <= pass_q + PASS_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_disparity_search_seq.sv
// Bench for disparity_search_seq: constant-pattern vector table, random searches against
// a flat SAD reference model, plus gap/stall, abort and async-reset sequences.
module tb_disparity_search_seq;

   localparam int PW = 3;
   localparam int NU = 16;
   localparam int NP = 2;
   localparam int WL = 16;
   localparam int CW = 7;
   localparam int DW = 5;
   localparam int ND = NU * NP;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CW-1:0]    cfg_thresh;
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_g;
   logic [NU*PW-1:0] in_f;
   logic             busy;
   logic [1:0]       pass_idx;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_disp;
   logic [CW-1:0]    out_cost;
   logic             out_conf;

   disparity_search_seq #(
      .PIX_W(PW), .NUM_UNITS(NU), .NUM_PASSES(NP), .WIN_LEN(WL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_thresh(cfg_thresh),
      .in_valid(in_valid), .in_ready(in_ready), .in_g(in_g), .in_f(in_f),
      .busy(busy), .pass_idx(pass_idx), .out_valid(out_valid), .out_ready(out_ready),
      .out_disp(out_disp), .out_cost(out_cost), .out_conf(out_conf)
   );

   typedef struct {
      logic [DW-1:0] disp;
      logic [CW-1:0] cost;
      logic          conf;
   } res_t;

   typedef struct {
      logic [PW-1:0]    g;
      logic [NU*PW-1:0] f0;
      logic [NU*PW-1:0] f1;
      logic [CW-1:0]    thresh;
      res_t             exp;
   } vec_t;

   vec_t             tbl [9];
   res_t             sb_q [$];
   logic [PW-1:0]    bg [NP][WL];
   logic [NU*PW-1:0] bf [NP][WL];
   int               checks = 0;
   int               failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: a result is consumed on every out_valid&out_ready handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'(0));
         end else begin
            res_t e;
            e = sb_q.pop_front();
            check("res_disp", 32'(out_disp), 32'(e.disp));
            check("res_cost", 32'(out_cost), 32'(e.cost));
            check("res_conf", 32'(out_conf), 32'(e.conf));
         end
      end
   end

   function automatic logic [NU*PW-1:0] pat(input logic [PW-1:0] base, input int u1,
                                            input logic [PW-1:0] v1, input int u2,
                                            input logic [PW-1:0] v2);
      logic [NU*PW-1:0] r;
      for (int u = 0; u < NU; u++)
         r[u*PW +: PW] = (u == u1) ? v1 : ((u == u2) ? v2 : base);
      return r;
   endfunction

   task automatic load_const(input vec_t v);
      for (int p = 0; p < NP; p++)
         for (int b = 0; b < WL; b++) begin
            bg[p][b] = v.g;
            bf[p][b] = (p == 0) ? v.f0 : v.f1;
         end
   endtask

   task automatic run_search(input logic [CW-1:0] thr, input res_t e, input bit gaps,
                             input int stall, input int abort_at);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("idle_before_start", 32'(busy), 32'(0));
      start = 1'b1;
      cfg_thresh = thr;
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_at < 0)
         sb_q.push_back(e);
      for (int p = 0; p < NP; p++) begin
         for (int b = 0; b < WL; b++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
               in_valid = 1'b0;
               in_g = PW'($urandom);
               in_f = (NU*PW)'({$urandom, $urandom});
               @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_g = bg[p][b];
            in_f = bf[p][b];
            if (p * WL + b == abort_at)
               abort = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
               @(posedge clk); #1; n++;
            end
            check("in_ready_accum", 32'(in_ready), 32'(1));
            check("pass_idx_accum", 32'(pass_idx), 32'(p));
            @(posedge clk); #1;
            if (abort) begin
               abort = 1'b0;
               in_valid = 1'b0;
               check("abort_busy", 32'(busy), 32'(0));
               check("abort_out_valid", 32'(out_valid), 32'(0));
               return;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = (stall == 0);
      check("reduce_out_valid", 32'(out_valid), 32'(0));
      check("reduce_in_ready", 32'(in_ready), 32'(0));
      check("reduce_pass_idx", 32'(pass_idx), 32'(NP - 1));
      @(posedge clk); #1;
      check("latency_out_valid", 32'(out_valid), 32'(1));
      for (int i = 0; i < stall; i++) begin
         start = 1'b1;
         check("stall_valid", 32'(out_valid), 32'(1));
         check("stall_disp", 32'(out_disp), 32'(e.disp));
         check("stall_cost", 32'(out_cost), 32'(e.cost));
         check("stall_conf", 32'(out_conf), 32'(e.conf));
         @(posedge clk); #1;
      end
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("post_hs_busy", 32'(busy), 32'(0));
      check("post_hs_valid", 32'(out_valid), 32'(0));
   endtask

   initial begin
      int   sad [ND];
      int   best;
      res_t e;
      logic [CW-1:0] thr;

      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_thresh = '0;
      in_valid = 1'b0; in_g = '0; in_f = '0; out_ready = 1'b1;

      tbl[0] = '{3'd3, pat(0, 5, 3, -1, 0), pat(0, -1, 0, -1, 0), 7'd0,   '{5'd5,  7'd0,   1'b1}};
      tbl[1] = '{3'd3, pat(3, -1, 0, -1, 0), pat(3, -1, 0, -1, 0), 7'd0,  '{5'd0,  7'd0,   1'b1}};
      tbl[2] = '{3'd3, pat(2, -1, 0, -1, 0), pat(2, 2, 3, -1, 0), 7'd0,   '{5'd18, 7'd0,   1'b1}};
      tbl[3] = '{3'd3, pat(2, -1, 0, -1, 0), pat(2, -1, 0, -1, 0), 7'd0,  '{5'd0,  7'd16,  1'b0}};
      tbl[4] = '{3'd3, pat(2, -1, 0, -1, 0), pat(2, -1, 0, -1, 0), 7'd16, '{5'd0,  7'd16,  1'b1}};
      tbl[5] = '{3'd7, pat(0, -1, 0, -1, 0), pat(0, -1, 0, -1, 0), 7'd111,'{5'd0,  7'd112, 1'b0}};
      tbl[6] = '{3'd0, pat(1, -1, 0, -1, 0), pat(1, 15, 0, -1, 0), 7'd5,  '{5'd31, 7'd0,   1'b1}};
      tbl[7] = '{3'd4, pat(0, 9, 4, 12, 4), pat(0, -1, 0, -1, 0), 7'd0,   '{5'd9,  7'd0,   1'b1}};
      tbl[8] = '{3'd4, pat(0, 7, 5, -1, 0), pat(0, 1, 5, -1, 0), 7'd15,   '{5'd7,  7'd16,  1'b0}};

      #12;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_disp", 32'(out_disp), 32'(0));
      check("rst_out_cost", 32'(out_cost), 32'(0));
      check("rst_out_conf", 32'(out_conf), 32'(0));
      check("rst_pass_idx", 32'(pass_idx), 32'(0));
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_after_rst", 32'(busy), 32'(0));

      for (int i = 0; i < 9; i++) begin
         load_const(tbl[i]);
         run_search(tbl[i].thresh, tbl[i].exp, 1'b0, 0, -1);
      end

      // Same data as the gap-free run, now with input gaps and a 10-cycle output stall.
      load_const(tbl[2]);
      run_search(tbl[2].thresh, tbl[2].exp, 1'b1, 10, -1);

      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < NP; p++)
            for (int b = 0; b < WL; b++) begin
               bg[p][b] = PW'($urandom_range(0, 7));
               bf[p][b] = (NU*PW)'({$urandom, $urandom});
            end
         for (int d = 0; d < ND; d++) begin
            sad[d] = 0;
            for (int b = 0; b < WL; b++) begin
               int fv, gv;
               fv = int'(bf[d / NU][b][(d % NU)*PW +: PW]);
               gv = int'(bg[d / NU][b]);
               sad[d] += (fv > gv) ? fv - gv : gv - fv;
            end
         end
         best = 0;
         for (int d = 1; d < ND; d++)
            if (sad[d] < sad[best])
               best = d;
         thr = CW'($urandom_range(15, 45));
         e.disp = DW'(best);
         e.cost = CW'(sad[best]);
         e.conf = (sad[best] <= int'(thr));
         run_search(thr, e, 1'b1, int'($urandom_range(0, 3)), -1);
      end

      load_const(tbl[0]);
      run_search(7'd0, tbl[0].exp, 1'b0, 0, WL + 7);
      run_search(7'd0, tbl[0].exp, 1'b0, 0, -1);

      // Asynchronous reset in the middle of pass 1; outputs must clear before the next edge.
      load_const(tbl[2]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_g = 3'd3; in_f = pat(2, -1, 0, -1, 0);
      repeat (21) @(posedge clk);
      #1;
      check("pre_rst_pass_idx", 32'(pass_idx), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_in_ready", 32'(in_ready), 32'(0));
      check("arst_out_valid", 32'(out_valid), 32'(0));
      check("arst_out_disp", 32'(out_disp), 32'(0));
      check("arst_out_cost", 32'(out_cost), 32'(0));
      check("arst_out_conf", 32'(out_conf), 32'(0));
      check("arst_pass_idx", 32'(pass_idx), 32'(0));
      in_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_arst_busy", 32'(busy), 32'(0));
      check("idle_after_arst_valid", 32'(out_valid), 32'(0));

      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
